// File: rtl/user_slv_pkg.sv
// Shared definitions for the user slave register block: register indices,
// CTRL bit positions, FSM state encoding and a byte-lane merge helper.
package user_slv_pkg;

   localparam logic [2:0] RegCtrl = 3'd0;
   localparam logic [2:0] RegStat = 3'd1;
   localparam logic [2:0] RegCmp  = 3'd2;
   localparam logic [2:0] RegCnt  = 3'd3;
   localparam logic [2:0] RegScr0 = 3'd4;
   localparam logic [2:0] RegScr1 = 3'd5;
   localparam logic [2:0] RegScr2 = 3'd6;
   localparam logic [2:0] RegScr3 = 3'd7;

   localparam int unsigned CtrlEn     = 0;
   localparam int unsigned CtrlIrqEn  = 1;
   localparam int unsigned CtrlReload = 2;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   // Replace only the byte lanes selected by wstrb
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/user_slv_timer.sv
// Free-running compare timer: CNT/CMP registers, compare detection and
// optional reload. Bus writes to CNT override the timer update.
module user_slv_timer
   import user_slv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic        reload_i,
   input  logic        cmp_we_i,
   input  logic        cnt_we_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   output logic [31:0] cnt_o,
   output logic [31:0] cmp_o,
   output logic        match_o
);

   logic [31:0] r_cnt;
   logic [31:0] r_cmp;
   logic [31:0] w_cnt_next;
   logic        w_match;

   assign w_match = en_i & (r_cnt == r_cmp);

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_match) begin
         if (reload_i) w_cnt_next = '0;
      end else if (en_i) begin
         w_cnt_next = r_cnt + 32'd1;
      end
      // Unwritten lanes keep the pre-increment value
      if (cnt_we_i) w_cnt_next = apply_wstrb(r_cnt, wdata_i, wstrb_i);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
         r_cmp <= '0;
      end else begin
         r_cnt <= w_cnt_next;
         if (cmp_we_i) r_cmp <= apply_wstrb(r_cmp, wdata_i, wstrb_i);
      end
   end

   assign cnt_o   = r_cnt;
   assign cmp_o   = r_cmp;
   assign match_o = w_match;

endmodule

// File: rtl/user_slv_regs.sv
// Memory-mapped slave with wait-state handshake FSM, control/status/scratch
// register bank and a compare timer with level interrupt.
module user_slv_regs
   import user_slv_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned WAIT_CYC  = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        core_valid_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   input  logic [3:0]  core_wstrb_i,
   output logic [31:0] core_rdata_o,
   output logic        core_ready_o,
   output logic        irq_o
);

   localparam logic [3:0] WaitLoad = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

   state_e      r_state;
   logic [3:0]  r_wait_cnt;
   logic [2:0]  r_idx;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_ready;
   logic [2:0]  r_ctrl;
   logic        r_pend;
   logic        r_irq;
   logic [31:0] r_scr [4];

   logic        w_hit;
   logic        w_commit;
   logic        w_we_ctrl;
   logic        w_w1c_pend;
   logic        w_match;
   logic [31:0] w_cnt;
   logic [31:0] w_cmp;
   logic [31:0] w_rdata;
   logic        w_unused_addr;

   assign w_hit         = core_valid_i & (core_addr_i[31:5] == BASE_ADDR[31:5]);
   assign w_unused_addr = ^core_addr_i[1:0];
   assign w_commit      = (r_state == StResp) & (r_wstrb != 4'b0000);
   assign w_we_ctrl     = w_commit & (r_idx == RegCtrl) & r_wstrb[0];
   assign w_w1c_pend    = w_commit & (r_idx == RegStat) & r_wstrb[0] & r_wdata[0];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= StIdle;
         r_wait_cnt <= '0;
         r_idx      <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_hit) begin
                  r_idx   <= core_addr_i[4:2];
                  r_wdata <= core_wdata_i;
                  r_wstrb <= core_wstrb_i;
                  if (WAIT_CYC == 0) begin
                     r_state <= StResp;
                     r_ready <= 1'b1;
                  end else begin
                     r_state    <= StWait;
                     r_wait_cnt <= WaitLoad;
                  end
               end
            end
            StWait: begin
               if (r_wait_cnt == 4'd0) begin
                  r_state <= StResp;
                  r_ready <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            StResp:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ctrl <= '0;
         r_pend <= 1'b0;
         r_irq  <= 1'b0;
         for (int i = 0; i < 4; i++) r_scr[i] <= '0;
      end else begin
         r_irq <= r_pend & r_ctrl[CtrlIrqEn];
         // A bus write to CTRL takes precedence over the one-shot EN clear
         if (w_we_ctrl) begin
            r_ctrl <= r_wdata[2:0];
         end else if (w_match & ~r_ctrl[CtrlReload]) begin
            r_ctrl[CtrlEn] <= 1'b0;
         end
         if (w_match) begin
            r_pend <= 1'b1;
         end else if (w_w1c_pend) begin
            r_pend <= 1'b0;
         end
         for (int i = 0; i < 4; i++) begin
            if (w_commit && r_idx == RegScr0 + 3'(i)) begin
               r_scr[i] <= apply_wstrb(r_scr[i], r_wdata, r_wstrb);
            end
         end
      end
   end

   user_slv_timer u_timer (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .en_i     (r_ctrl[CtrlEn]),
      .reload_i (r_ctrl[CtrlReload]),
      .cmp_we_i (w_commit & (r_idx == RegCmp)),
      .cnt_we_i (w_commit & (r_idx == RegCnt)),
      .wdata_i  (r_wdata),
      .wstrb_i  (r_wstrb),
      .cnt_o    (w_cnt),
      .cmp_o    (w_cmp),
      .match_o  (w_match)
   );

   always_comb begin
      w_rdata = '0;
      if (r_state == StResp && r_wstrb == 4'b0000) begin
         unique case (r_idx)
            RegCtrl: w_rdata = {29'b0, r_ctrl};
            RegStat: w_rdata = {31'b0, r_pend};
            RegCmp:  w_rdata = w_cmp;
            RegCnt:  w_rdata = w_cnt;
            RegScr0: w_rdata = r_scr[0];
            RegScr1: w_rdata = r_scr[1];
            RegScr2: w_rdata = r_scr[2];
            RegScr3: w_rdata = r_scr[3];
            default: w_rdata = '0;
         endcase
      end
   end

   assign core_rdata_o = w_rdata;
   assign core_ready_o = r_ready;
   assign irq_o        = r_irq;

endmodule

// File: tb/tb_user_slv_regs.sv
// Bench for user_slv_regs: cycle-level reference model plus directed
// transactions with literal expectations, and a WAIT_CYC=3 reset-abort case.
module tb_user_slv_regs;

   localparam logic [31:0] Base = 32'h8000_1000;
   localparam int          Wait1 = 1;

   logic        clk = 1'b0;
   logic        rst_n, rst3_n;
   logic        v, v3;
   logic [31:0] a, a3, wd, wd3;
   logic [3:0]  ws, ws3;
   logic [31:0] rd, rd3;
   logic        rdy, rdy3, irq, irq3;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   user_slv_regs #(.BASE_ADDR(Base), .WAIT_CYC(1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .core_valid_i(v), .core_addr_i(a),
      .core_wdata_i(wd), .core_wstrb_i(ws), .core_rdata_o(rd),
      .core_ready_o(rdy), .irq_o(irq)
   );

   user_slv_regs #(.BASE_ADDR(Base), .WAIT_CYC(3)) dut3 (
      .clk_i(clk), .rst_n_i(rst3_n), .core_valid_i(v3), .core_addr_i(a3),
      .core_wdata_i(wd3), .core_wstrb_i(ws3), .core_rdata_o(rd3),
      .core_ready_o(rdy3), .irq_o(irq3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   // Reference model: m_reg[0]=CTRL, [1]=STAT, [2]=CMP, [3]=CNT, [4..7]=SCR
   logic [31:0] m_reg [8];
   logic        m_irq, m_busy, m_ready;
   int          m_edge, m_resp_at;
   logic [2:0]  m_idx;
   logic [31:0] m_wd;
   logic [3:0]  m_ws;

   task automatic model_step();
      logic [31:0] ctrl, cnt;
      logic        ev, was_idle;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_reg[i] = '0;
         m_irq = 0; m_busy = 0; m_ready = 0; m_edge = 0; m_resp_at = 0;
         m_idx = 0; m_wd = 0; m_ws = 0;
         return;
      end
      m_edge++;
      ctrl = m_reg[0];
      cnt  = m_reg[3];
      ev   = ctrl[0] && (cnt == m_reg[2]);
      m_irq = m_reg[1][0] && ctrl[1];
      if (ev) begin
         m_reg[1] = 32'd1;
         if (ctrl[2]) m_reg[3] = '0;
         else m_reg[0][0] = 1'b0;
      end else if (ctrl[0]) begin
         m_reg[3] = cnt + 32'd1;
      end
      was_idle = !m_busy;
      if (m_ready) begin
         m_busy = 0;
         if (m_ws != 4'b0) begin
            case (m_idx)
               3'd0: if (m_ws[0]) m_reg[0] = {29'b0, m_wd[2:0]};
               3'd1: if (m_ws[0] && m_wd[0] && !ev) m_reg[1] = '0;
               3'd3: m_reg[3] = merge(cnt, m_wd, m_ws);
               default: m_reg[m_idx] = merge(m_reg[m_idx], m_wd, m_ws);
            endcase
         end
      end
      if (was_idle && v && a[31:5] == Base[31:5]) begin
         m_busy = 1; m_resp_at = m_edge + Wait1;
         m_idx = a[4:2]; m_wd = wd; m_ws = ws;
      end
      m_ready = m_busy && (m_edge == m_resp_at);
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      logic [31:0] exp_rd;
      @(negedge clk);
      if (rst_n) begin
         exp_rd = (m_ready && m_ws == 4'b0) ? m_reg[m_idx] : 32'd0;
         check("ready", 32'(rdy), 32'(m_ready));
         check("rdata", rd, exp_rd);
         check("irq", 32'(irq), 32'(m_irq));
      end
   end

   task automatic bus(input bit sel3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output int lat);
      @(negedge clk);
      if (sel3) begin v3 = 1; a3 = addr; wd3 = wdata; ws3 = strb; end
      else begin v = 1; a = addr; wd = wdata; ws = strb; end
      lat = 0;
      rdata = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (sel3 ? rdy3 : rdy) begin
            lat = i;
            rdata = sel3 ? rd3 : rd;
            break;
         end
         // Inputs after acceptance must not matter
         if (sel3) begin a3 = ~addr; wd3 = ~wdata; ws3 = ~strb; end
         else begin a = ~addr; wd = ~wdata; ws = ~strb; end
      end
      v = 0;
      v3 = 0;
      check("bus_done", 32'(lat != 0), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [31:0] r;
   int          lat, cnt_rdy;

   initial begin
      rst_n = 0; rst3_n = 0; v = 0; v3 = 0;
      a = '0; a3 = '0; wd = '0; wd3 = '0; ws = '0; ws3 = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(rdy), 32'd0);
      check("rst_rdata", rd, 32'd0);
      #2 rst_n = 1; rst3_n = 1;

      for (int i = 0; i < 8; i++) begin
         bus(0, Base + 32'(4 * i), 32'd0, 4'h0, r, lat);
         check($sformatf("rst_reg%0d", i), r, 32'd0);
      end

      bus(0, Base + 32'h10, 32'hDEAD_BEEF, 4'hF, r, lat);
      check("wr_latency", 32'(lat), 32'd2);
      bus(0, Base + 32'h10, 32'd0, 4'h0, r, lat);
      check("rd_latency", 32'(lat), 32'd2);
      check("scr0_rd", r, 32'hDEAD_BEEF);
      bus(0, Base + 32'h13, 32'd0, 4'h0, r, lat);
      check("scr0_rd_lowbits", r, 32'hDEAD_BEEF);

      bus(0, Base + 32'h14, 32'hAAAA_AAAA, 4'hF, r, lat);
      bus(0, Base + 32'h14, 32'h1122_3344, 4'b0101, r, lat);
      bus(0, Base + 32'h14, 32'd0, 4'h0, r, lat);
      check("scr1_strb", r, 32'hAA22_AA44);

      // One-shot compare
      bus(0, Base + 32'h08, 32'd5, 4'hF, r, lat);
      bus(0, Base + 32'h0C, 32'd0, 4'hF, r, lat);
      bus(0, Base + 32'h00, 32'hFFFF_FFFB, 4'hF, r, lat);
      repeat (12) @(negedge clk);
      check("oneshot_irq", 32'(irq), 32'd1);
      bus(0, Base + 32'h04, 32'd0, 4'h0, r, lat);
      check("oneshot_pend", r, 32'd1);
      bus(0, Base + 32'h00, 32'd0, 4'h0, r, lat);
      check("oneshot_ctrl", r, 32'd2);
      bus(0, Base + 32'h0C, 32'd0, 4'h0, r, lat);
      check("oneshot_cnt", r, 32'd5);
      bus(0, Base + 32'h04, 32'hFFFF_FFFF, 4'h1, r, lat);
      repeat (2) @(negedge clk);
      check("w1c_irq", 32'(irq), 32'd0);
      bus(0, Base + 32'h04, 32'd0, 4'h0, r, lat);
      check("w1c_pend", r, 32'd0);

      // Reload mode with W1C landing on the compare edge
      bus(0, Base + 32'h08, 32'd3, 4'hF, r, lat);
      bus(0, Base + 32'h0C, 32'd0, 4'hF, r, lat);
      bus(0, Base + 32'h00, 32'd7, 4'hF, r, lat);
      @(negedge clk);
      bus(0, Base + 32'h04, 32'd1, 4'h1, r, lat);
      bus(0, Base + 32'h0C, 32'd0, 4'h0, r, lat);
      check("reload_cnt", r, 32'd2);
      bus(0, Base + 32'h04, 32'd0, 4'h0, r, lat);
      check("reload_pend", r, 32'd1);
      bus(0, Base + 32'h00, 32'd0, 4'hF, r, lat);

      // Miss: no ready, FSM stays idle
      @(negedge clk);
      v = 1; a = Base + 32'h20; ws = 4'h0;
      cnt_rdy = 0;
      repeat (20) begin
         @(negedge clk);
         if (rdy) cnt_rdy++;
      end
      v = 0;
      check("miss_ready", 32'(cnt_rdy), 32'd0);
      bus(0, Base + 32'h10, 32'd0, 4'h0, r, lat);
      check("after_miss_lat", 32'(lat), 32'd2);

      // WAIT_CYC=3: reset during the wait phase drops the write
      @(negedge clk);
      v3 = 1; a3 = Base + 32'h10; wd3 = 32'h1234_5678; ws3 = 4'hF;
      cnt_rdy = 0;
      repeat (2) begin
         @(negedge clk);
         if (rdy3) cnt_rdy++;
      end
      #2 rst3_n = 0; v3 = 0;
      repeat (3) begin
         @(negedge clk);
         if (rdy3) cnt_rdy++;
      end
      #2 rst3_n = 1;
      repeat (4) begin
         @(negedge clk);
         if (rdy3) cnt_rdy++;
      end
      check("abort_ready", 32'(cnt_rdy), 32'd0);
      bus(1, Base + 32'h10, 32'd0, 4'h0, r, lat);
      check("abort_scr0", r, 32'd0);
      check("w3_latency", 32'(lat), 32'd4);
      bus(1, Base + 32'h10, 32'hCAFE_F00D, 4'hF, r, lat);
      bus(1, Base + 32'h10, 32'd0, 4'h0, r, lat);
      check("w3_rd", r, 32'hCAFE_F00D);
      check("w3_rd_lat", 32'(lat), 32'd4);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
